reset_sequencer: RTL and testbench
==================================

# reset_sequencer

Parametrised reset controller that generates `CHANNELS` independent active-high synchronous reset outputs. Reset release is staggered across channels after a power-on reset or a filtered software reset command. A command resets only the channels selected by a mask. It sits between the top-level clock/reset pins and the functional blocks (UART, future peripherals), and replaces single-output reset control with per-domain sequencing, glitch filtering and a command counter.

## Interface
Parameters:
- `CHANNELS`, 4: number of reset outputs, 1..16.
- `HOLD_CYCLES`, 8: cycles every asserted channel is held before the first release slot, ≥1.
- `STAGGER_CYCLES`, 4: spacing between consecutive channel release slots, ≥1.
- `FILTER_CYCLES`, 3: consecutive high samples of the strobe needed to qualify a command, ≥1.

Ports:
- `clk` in 1: single clock. All logic uses its rising edge.
- `reset` in 1: synchronous, active-high. Forces a full all-channel sequence.
- `cmd_reset_strobe` in 1: software reset request. Level sampled and filtered.
- `chan_mask` in CHANNELS: channels affected by a command. Sampled on the qualifying edge.
- `reset_out` out CHANNELS: per-channel reset, active high. Bit i drives domain i.
- `ready` out 1: high when every channel is released and the block is idle.
- `event_count` out 8: count of qualified commands, saturating at 255.

## Operation
- States: IDLE, HOLD, RELEASE.
- Outputs while `reset` is high: `reset_out` all ones, `ready`=0, `event_count`=0, state HOLD, all counters 0, filter disarmed.
- `reset` high on any cycle aborts any sequence in progress and restarts a full sequence.
- HOLD: hold counter runs for HOLD_CYCLES edges, then the state goes to RELEASE with slot index 0.
- RELEASE: slot i clears `reset_out[i]` only if the channel is part of the active set. A slot is STAGGER_CYCLES edges long. After slot CHANNELS-1 the state goes to IDLE.
- Active set: all ones after `reset`; the sampled `chan_mask` after a command.
- Channels outside the active set keep their value. They still consume their stagger slot, so timing does not depend on the mask.
- IDLE: `ready`=1. The filter counts consecutive high samples of `cmd_reset_strobe` and clears to 0 on any low sample.
- Qualification: the FILTER_CYCLES-th consecutive high sample, taken while armed.
- On qualification:
  - Masked channels assert on that edge.
  - `ready` falls on that edge.
  - `event_count` increments on that edge, saturating at 255.
  - State goes to HOLD.
- Zero `chan_mask` at qualification: `event_count` still increments; no channel asserts, state stays IDLE, `ready` stays 1.
- Re-arm rule: after a qualification the filter is disarmed until `cmd_reset_strobe` is sampled low. A continuously held strobe therefore produces exactly one command.
- Strobe outside IDLE is ignored and the filter counter is held at 0.

## Timing
- Edge A: the last edge where `reset` is sampled high, or the qualifying edge of a command.
- Channel i releases on edge A + HOLD_CYCLES + i·STAGGER_CYCLES, i.e. `reset_out[i]` reads 0 after that edge.
- `ready` rises on edge A + HOLD_CYCLES + (CHANNELS−1)·STAGGER_CYCLES + 1.
- Defaults: releases at A+8, A+12, A+16, A+20; `ready` at A+21.
- Command latency: strobe high from edge F1 gives qualification at F1 + FILTER_CYCLES − 1, which is edge A.
- All outputs are registered. There is no combinational path from any input to any output.
- Counter widths: $clog2 of the max value + 1. For STAGGER_CYCLES=1 each slot lasts one edge.

## Structure
- Package `reset_seq_pkg`: state enum {IDLE, HOLD, RELEASE}, `EVENT_W`=8 constant, counter-width helper function.
- Sub-module `strobe_filter`: consecutive-sample counter, armed flag, enable input (high in IDLE), one-cycle `qualified` output.
- The top holds the FSM, hold/slot counters, active-set register and event counter.

## Test plan
- Power-on with defaults: `reset` high for 3 cycles, then low → `reset_out` reads 1111, then 1110@A+8, 1100@A+12, 1000@A+16, 0000@A+20; `ready`=1 @A+21.
- Glitch rejection: strobe high for 2 cycles, low, high for 2 cycles, all in IDLE → no assertion, `event_count`=0, `ready` stays 1.
- Masked command: `chan_mask`=0101, strobe held 3 cycles → `reset_out`=0101 on the qualifying edge; bit0 clears @A+8, bit2 @A+16; `ready` @A+21; `event_count`=1.
- Held strobe: strobe high for 100 cycles → exactly one sequence, `event_count`=1. Drop low, then 3 more high samples → second sequence, `event_count`=2.
- Reset mid-sequence: assert `reset` at A+14 during a masked command → `reset_out`=1111 immediately, full release timing restarts from the new A, `event_count`=0.
- Saturation and zero mask: 260 commands with mask 0001 → `event_count` stops at 255. One command with mask 0000 → no state change, `ready` stays 1.

Source files
------------

// File: rtl/reset_seq_pkg.sv
// rtl/reset_seq_pkg.sv - shared state type, widths and counter-width helper for the reset sequencer
package reset_seq_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HOLD    = 2'd1,
        RELEASE = 2'd2
    } seq_state_e;

    localparam int EVENT_W = 8;
    localparam logic [EVENT_W-1:0] EVENT_MAX = '1;

    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : ($clog2(max_val) + 1);
    endfunction

endpackage

// File: rtl/reset_sequencer_if.sv
// rtl/reset_sequencer_if.sv - command/status bundle between a reset requester and the reset sequencer
interface reset_sequencer_if #(
    parameter int CHANNELS = 4
) ();
    import reset_seq_pkg::*;

    logic                cmd_reset_strobe;
    logic [CHANNELS-1:0] chan_mask;
    logic [CHANNELS-1:0] reset_out;
    logic                ready;
    logic [EVENT_W-1:0]  event_count;

    modport master (
        output cmd_reset_strobe,
        output chan_mask,
        input  reset_out,
        input  ready,
        input  event_count
    );

    modport slave (
        input  cmd_reset_strobe,
        input  chan_mask,
        output reset_out,
        output ready,
        output event_count
    );

endinterface

// File: rtl/reset_sequencer_strobe_filter.sv
// rtl/reset_sequencer_strobe_filter.sv - consecutive-sample glitch filter with re-arm on a low sample
module strobe_filter
    import reset_seq_pkg::*;
#(
    parameter int FILTER_CYCLES = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic enable_i,
    input  logic strobe_i,
    output logic qualified_o
);

    localparam int CNT_W = cnt_width(FILTER_CYCLES);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             armed_q, armed_d;

    // Qualification is flagged on the very edge that takes the final high sample.
    always_comb begin
        cnt_d       = '0;
        armed_d     = armed_q;
        qualified_o = 1'b0;
        if (!strobe_i) begin
            armed_d = 1'b1;
        end else if (enable_i && armed_q) begin
            if (cnt_q == CNT_W'(FILTER_CYCLES - 1)) begin
                qualified_o = 1'b1;
                armed_d     = 1'b0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q   <= '0;
            armed_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            armed_q <= armed_d;
        end
    end

endmodule

// File: rtl/reset_sequencer.sv
// rtl/reset_sequencer.sv - staggered multi-channel reset release with filtered, masked software reset commands
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int CHANNELS       = 4,
    parameter int HOLD_CYCLES    = 8,
    parameter int STAGGER_CYCLES = 4,
    parameter int FILTER_CYCLES  = 3
) (
    input  logic               clk,
    input  logic               reset,
    reset_sequencer_if.slave   bus
);

    localparam int HOLD_W = cnt_width(HOLD_CYCLES);
    localparam int STAG_W = cnt_width(STAGGER_CYCLES);
    localparam int SLOT_W = cnt_width(CHANNELS - 1);

    seq_state_e          state_q, state_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic [STAG_W-1:0]   stag_q, stag_d;
    logic [SLOT_W-1:0]   slot_q, slot_d;
    logic [CHANNELS-1:0] active_q, active_d;
    logic [CHANNELS-1:0] rst_out_q, rst_out_d;
    logic                ready_q, ready_d;
    logic [EVENT_W-1:0]  event_q, event_d;
    logic [CHANNELS-1:0] slot_onehot;
    logic                qualified;

    strobe_filter #(
        .FILTER_CYCLES (FILTER_CYCLES)
    ) u_filter (
        .clk         (clk),
        .reset       (reset),
        .enable_i    (state_q == IDLE),
        .strobe_i    (bus.cmd_reset_strobe),
        .qualified_o (qualified)
    );

    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        stag_d      = stag_q;
        slot_d      = slot_q;
        active_d    = active_q;
        rst_out_d   = rst_out_q;
        event_d     = event_q;
        slot_onehot = '0;

        case (state_q)
            IDLE: begin
                if (qualified) begin
                    if (event_q != EVENT_MAX) begin
                        event_d = event_q + 1'b1;
                    end
                    if (bus.chan_mask != '0) begin
                        rst_out_d = rst_out_q | bus.chan_mask;
                        active_d  = bus.chan_mask;
                        hold_d    = '0;
                        state_d   = HOLD;
                    end
                end
            end
            // Leaving HOLD is itself slot 0, so channel 0 drops on the same edge.
            HOLD: begin
                if (hold_q == HOLD_W'(HOLD_CYCLES - 1)) begin
                    state_d      = RELEASE;
                    slot_d       = '0;
                    stag_d       = '0;
                    rst_out_d[0] = rst_out_q[0] & ~active_q[0];
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            // The last slot ends one edge after its release rather than a full stagger later.
            RELEASE: begin
                if (slot_q == SLOT_W'(CHANNELS - 1)) begin
                    state_d = IDLE;
                end else if (stag_q == STAG_W'(STAGGER_CYCLES - 1)) begin
                    slot_d      = slot_q + 1'b1;
                    stag_d      = '0;
                    slot_onehot = CHANNELS'(1) << slot_d;
                    rst_out_d   = rst_out_q & ~(active_q & slot_onehot);
                end else begin
                    stag_d = stag_q + 1'b1;
                end
            end
            default: begin
                state_d = HOLD;
                hold_d  = '0;
            end
        endcase

        ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= HOLD;
            hold_q    <= '0;
            stag_q    <= '0;
            slot_q    <= '0;
            active_q  <= '1;
            rst_out_q <= '1;
            ready_q   <= 1'b0;
            event_q   <= '0;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            stag_q    <= stag_d;
            slot_q    <= slot_d;
            active_q  <= active_d;
            rst_out_q <= rst_out_d;
            ready_q   <= ready_d;
            event_q   <= event_d;
        end
    end

    assign bus.reset_out   = rst_out_q;
    assign bus.ready       = ready_q;
    assign bus.event_count = event_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// tb/tb_reset_sequencer.sv - self-checking bench for reset_sequencer with a timing-formula reference model
module tb_reset_sequencer;
    import reset_seq_pkg::*;

    localparam int C = 4;
    localparam int H = 8;
    localparam int S = 4;
    localparam int F = 3;

    logic clk = 1'b0;
    logic reset;

    reset_sequencer_if #(.CHANNELS(C)) bus ();

    reset_sequencer #(
        .CHANNELS       (C),
        .HOLD_CYCLES    (H),
        .STAGGER_CYCLES (S),
        .FILTER_CYCLES  (F)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Reference model: outputs derived from edges elapsed since edge A.
    logic [C-1:0] m_out, m_act, s_mask;
    logic         s_rst, s_stb;
    int           m_evt, m_t, m_run;
    bit           m_busy, m_armed;

    initial begin
        forever begin
            @(posedge clk);
            s_rst  = reset;
            s_stb  = bus.cmd_reset_strobe;
            s_mask = bus.chan_mask;
            if (s_rst) begin
                m_out = '1; m_act = '1; m_evt = 0; m_t = 0;
                m_busy = 1'b1; m_run = 0; m_armed = 1'b0;
            end else if (m_busy) begin
                m_t++;
                for (int i = 0; i < C; i++)
                    if (m_act[i] && m_t == H + i * S) m_out[i] = 1'b0;
                if (m_t == H + (C - 1) * S + 1) m_busy = 1'b0;
                m_run = 0;
                if (!s_stb) m_armed = 1'b1;
            end else if (!s_stb) begin
                m_run = 0;
                m_armed = 1'b1;
            end else if (m_armed) begin
                m_run++;
                if (m_run == F) begin
                    m_run = 0;
                    m_armed = 1'b0;
                    if (m_evt < 255) m_evt++;
                    if (s_mask != '0) begin
                        m_out  = m_out | s_mask;
                        m_act  = s_mask;
                        m_busy = 1'b1;
                        m_t    = 0;
                    end
                end
            end
            @(negedge clk);
            chk("model_reset_out", {28'd0, bus.reset_out}, {28'd0, m_out});
            chk("model_ready", {31'd0, bus.ready}, {31'd0, !m_busy});
            chk("model_event_count", {24'd0, bus.event_count}, m_evt);
        end
    end

    initial begin
        reset = 1'b1;
        bus.cmd_reset_strobe = 1'b0;
        bus.chan_mask = '0;

        // Power-on: edge A is the third posedge.
        tick(3);
        reset = 1'b0;
        chk("por_out_A", {28'd0, bus.reset_out}, 32'hF);
        chk("por_ready_A", {31'd0, bus.ready}, 32'd0);
        chk("por_evt_A", {24'd0, bus.event_count}, 32'd0);
        tick(7);  chk("por_out_A7", {28'd0, bus.reset_out}, 32'hF);
        tick(1);  chk("por_out_A8", {28'd0, bus.reset_out}, 32'hE);
        tick(4);  chk("por_out_A12", {28'd0, bus.reset_out}, 32'hC);
        tick(4);  chk("por_out_A16", {28'd0, bus.reset_out}, 32'h8);
        tick(4);  chk("por_out_A20", {28'd0, bus.reset_out}, 32'h0);
        chk("por_ready_A20", {31'd0, bus.ready}, 32'd0);
        tick(1);  chk("por_ready_A21", {31'd0, bus.ready}, 32'd1);

        // Glitch rejection
        bus.chan_mask = 4'b1111;
        bus.cmd_reset_strobe = 1'b1; tick(2);
        bus.cmd_reset_strobe = 1'b0; tick(1);
        bus.cmd_reset_strobe = 1'b1; tick(2);
        bus.cmd_reset_strobe = 1'b0; tick(2);
        chk("glitch_evt", {24'd0, bus.event_count}, 32'd0);
        chk("glitch_ready", {31'd0, bus.ready}, 32'd1);
        chk("glitch_out", {28'd0, bus.reset_out}, 32'h0);

        // Masked command 0101
        bus.chan_mask = 4'b0101;
        bus.cmd_reset_strobe = 1'b1; tick(3);
        bus.cmd_reset_strobe = 1'b0;
        chk("mask_out_A", {28'd0, bus.reset_out}, 32'h5);
        chk("mask_ready_A", {31'd0, bus.ready}, 32'd0);
        chk("mask_evt_A", {24'd0, bus.event_count}, 32'd1);
        tick(8);  chk("mask_out_A8", {28'd0, bus.reset_out}, 32'h4);
        tick(8);  chk("mask_out_A16", {28'd0, bus.reset_out}, 32'h0);
        tick(4);  chk("mask_ready_A20", {31'd0, bus.ready}, 32'd0);
        tick(1);  chk("mask_ready_A21", {31'd0, bus.ready}, 32'd1);

        // Held strobe gives exactly one command until it drops
        bus.chan_mask = 4'b1111;
        bus.cmd_reset_strobe = 1'b1; tick(100);
        chk("held_evt", {24'd0, bus.event_count}, 32'd2);
        chk("held_ready", {31'd0, bus.ready}, 32'd1);
        bus.cmd_reset_strobe = 1'b0; tick(1);
        bus.cmd_reset_strobe = 1'b1; tick(3);
        chk("rearm_out", {28'd0, bus.reset_out}, 32'hF);
        chk("rearm_evt", {24'd0, bus.event_count}, 32'd3);
        bus.cmd_reset_strobe = 1'b0; tick(22);
        chk("rearm_ready", {31'd0, bus.ready}, 32'd1);

        // Reset at A+14 of a masked command
        bus.chan_mask = 4'b0101;
        bus.cmd_reset_strobe = 1'b1; tick(3);
        bus.cmd_reset_strobe = 1'b0;
        chk("mid_evt_A", {24'd0, bus.event_count}, 32'd4);
        tick(13); chk("mid_out_A13", {28'd0, bus.reset_out}, 32'h4);
        reset = 1'b1; tick(1);
        reset = 1'b0;
        chk("mid_out_rst", {28'd0, bus.reset_out}, 32'hF);
        chk("mid_evt_rst", {24'd0, bus.event_count}, 32'd0);
        chk("mid_ready_rst", {31'd0, bus.ready}, 32'd0);
        tick(8);  chk("mid_out_A8", {28'd0, bus.reset_out}, 32'hE);
        tick(13); chk("mid_ready_A21", {31'd0, bus.ready}, 32'd1);

        // Zero mask: counts but changes nothing else
        bus.chan_mask = 4'b0000;
        bus.cmd_reset_strobe = 1'b1; tick(3);
        chk("zero_evt", {24'd0, bus.event_count}, 32'd1);
        chk("zero_ready", {31'd0, bus.ready}, 32'd1);
        chk("zero_out", {28'd0, bus.reset_out}, 32'h0);
        bus.cmd_reset_strobe = 1'b0; tick(2);

        // Saturation
        bus.chan_mask = 4'b0001;
        for (int n = 0; n < 260; n++) begin
            bus.cmd_reset_strobe = 1'b1; tick(3);
            bus.cmd_reset_strobe = 1'b0; tick(22);
        end
        chk("sat_evt", {24'd0, bus.event_count}, 32'd255);
        chk("sat_ready", {31'd0, bus.ready}, 32'd1);
        bus.chan_mask = 4'b0000;
        bus.cmd_reset_strobe = 1'b1; tick(3);
        bus.cmd_reset_strobe = 1'b0; tick(2);
        chk("sat_zero_evt", {24'd0, bus.event_count}, 32'd255);
        chk("sat_zero_out", {28'd0, bus.reset_out}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
